// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: round-robin scheduler that time-shares a single bit-serial
// full-adder slice (plus carry flop) among NUM_REQ requesters. Each operation
// captures the winner's operands, shifts them LSB-first for WIDTH cycles, then
// registers sum/cout and pulses done tagged with the requester index.
// Optional build macro: SERIAL_ADD_SUB_EN adds a per-requester 'sub' input that
// turns the operation into A-B (B inverted at capture, carry-in forced to 1).
module serial_add_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
`ifdef SERIAL_ADD_SUB_EN
    input  logic [NUM_REQ-1:0]         sub,
`endif
    input  logic [NUM_REQ*WIDTH-1:0]   op_a,
    input  logic [NUM_REQ*WIDTH-1:0]   op_b,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    output logic                       done,
    output logic [ID_W-1:0]            done_id,
    output logic [WIDTH-1:0]           sum,
    output logic                       cout
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    win_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   acc_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               busy_q;
    logic               done_q;
    logic [ID_W-1:0]    done_id_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;

    logic               win_found_d;
    logic [ID_W-1:0]    win_idx_d;
    logic [ID_W:0]      cand_d;
    logic [WIDTH-1:0]   cap_a_d;
    logic [WIDTH-1:0]   cap_b_d;
    logic               cap_cin_d;
    logic               s_d;
    logic               carry_d;

    // Round-robin search: first requesting index at or above the pointer, wrapping.
    // Scanning from the farthest candidate down lets the nearest one win last.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        cand_d      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_d = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand_d >= (ID_W+1)'(NUM_REQ)) begin
                cand_d = cand_d - (ID_W+1)'(NUM_REQ);
            end
            if (req[cand_d[ID_W-1:0]]) begin
                win_found_d = 1'b1;
                win_idx_d   = cand_d[ID_W-1:0];
            end
        end
    end

    // Operand slices of the current winner, with optional subtract preconditioning.
    always_comb begin
        cap_a_d   = op_a[int'(win_idx_d)*WIDTH +: WIDTH];
        cap_b_d   = op_b[int'(win_idx_d)*WIDTH +: WIDTH];
        cap_cin_d = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        if (sub[win_idx_d]) begin
            cap_b_d   = ~cap_b_d;
            cap_cin_d = 1'b1;
        end
`endif
    end

    // The shared serial adder slice: one full adder on the operand LSBs.
    always_comb begin
        s_d     = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        a_q     <= cap_a_d;
                        b_q     <= cap_b_d;
                        carry_q <= cap_cin_d;
                        win_q   <= win_idx_d;
                        gnt_q   <= NUM_REQ'(1) << win_idx_d;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    gnt_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= carry_d;
                    acc_q   <= {s_d, acc_q[WIDTH-1:1]};
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        sum_q     <= {s_d, acc_q[WIDTH-1:1]};
                        cout_q    <= carry_d;
                        done_id_q <= win_q;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (win_q == ID_W'(NUM_REQ - 1)) begin
                        ptr_q <= '0;
                    end else begin
                        ptr_q <= win_q + 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign sum     = sum_q;
    assign cout    = cout_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed testbench for serial_add_arbiter (WIDTH=4, NUM_REQ=4).
module tb_serial_add_arbiter;

    localparam int WIDTH   = 4;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
`ifdef SERIAL_ADD_SUB_EN
    logic [NUM_REQ-1:0]       sub;
`endif
    logic [NUM_REQ*WIDTH-1:0] op_a;
    logic [NUM_REQ*WIDTH-1:0] op_b;
    logic [NUM_REQ-1:0]       gnt;
    logic                     busy;
    logic                     done;
    logic [ID_W-1:0]          done_id;
    logic [WIDTH-1:0]         sum;
    logic                     cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_add_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
`ifdef SERIAL_ADD_SUB_EN
        .sub     (sub),
`endif
        .op_a    (op_a),
        .op_b    (op_b),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sum     (sum),
        .cout    (cout)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_ops(input int idx, input logic [3:0] a, input logic [3:0] b);
        op_a[idx*WIDTH +: WIDTH] = a;
        op_b[idx*WIDTH +: WIDTH] = b;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // Raise r, drop each bit once granted, collect observations until done (bounded).
    task automatic run_req(input logic [3:0] r, output int gtick, output int gcnt,
                           output int dtick, output logic [3:0] g, output logic [3:0] s,
                           output logic c, output logic [1:0] id, output int busy_lo,
                           output int overlap, output logic busy_after);
        gtick = -1; gcnt = 0; dtick = -1; g = '0; s = '0; c = 1'b0; id = '0;
        busy_lo = 0; overlap = 0; busy_after = 1'b1;
        req = r;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (gnt != 0) begin
                gcnt++;
                if (gtick < 0) begin
                    gtick = n;
                    g = gnt;
                    req = req & ~gnt;
                end
            end
            if (gnt != 0 && done) overlap++;
            if (gtick >= 0 && !busy) busy_lo++;
            if (done) begin
                dtick = n; s = sum; c = cout; id = done_id;
                break;
            end
        end
        tick();
        busy_after = busy;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req = '0;
        op_a = '0;
        op_b = '0;
`ifdef SERIAL_ADD_SUB_EN
        sub = '0;
`endif
        tick();
        tick();
        checks++;
        if ({gnt, busy, done, done_id, sum, cout} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b busy=%b done=%b id=%0d sum=%0d cout=%b, want all 0",
                     gnt, busy, done, done_id, sum, cout);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single_add();
        int gt, gc, dt, bl, ov; logic [3:0] g, s; logic c, ba; logic [1:0] id;
        set_ops(0, 4'd5, 4'd6);
        run_req(4'b0001, gt, gc, dt, g, s, c, id, bl, ov, ba);
        checks++; if (gt !== 1) begin errors++; $display("FAIL single_gnt_tick: got %0d want 1", gt); end
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", g); end
        checks++; if (gc !== 1) begin errors++; $display("FAIL single_gnt_len: got %0d want 1", gc); end
        checks++; if (dt !== 6) begin errors++; $display("FAIL single_done_tick: got %0d want 6", dt); end
        checks++; if (s !== 4'd11) begin errors++; $display("FAIL single_sum: got %0d want 11", s); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL single_cout: got %b want 0", c); end
        checks++; if (id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", id); end
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", ba); end
    endtask

    task automatic test_overflow();
        int gt, gc, dt, bl, ov; logic [3:0] g, s; logic c, ba; logic [1:0] id;
        set_ops(1, 4'd9, 4'd8);
        run_req(4'b0010, gt, gc, dt, g, s, c, id, bl, ov, ba);
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL ovf_gnt: got %b want 0010", g); end
        checks++; if (s !== 4'd1) begin errors++; $display("FAIL ovf_sum: got %0d want 1", s); end
        checks++; if (c !== 1'b1) begin errors++; $display("FAIL ovf_cout: got %b want 1", c); end
        checks++; if (id !== 2'd1) begin errors++; $display("FAIL ovf_id: got %0d want 1", id); end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_s [4] = '{4'd7, 4'd9, 4'd3, 4'd14};
        logic exp_c [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int ng, nd, last_g, ov;
        ng = 0; nd = 0; last_g = 0; ov = 0;
        do_reset();
        set_ops(0, 4'd3, 4'd4);
        set_ops(1, 4'd7, 4'd2);
        set_ops(2, 4'd10, 4'd9);
        set_ops(3, 4'd15, 4'd15);
        req = 4'b1111;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (gnt != 0 && done) ov++;
            if (gnt != 0 && ng < 5) begin
                checks++;
                if (gnt !== (4'(1) << order[ng])) begin
                    errors++;
                    $display("FAIL rr_gnt_%0d: got %b want one-hot %0d", ng, gnt, order[ng]);
                end
                if (ng > 0) begin
                    checks++;
                    if (n - last_g !== 7) begin
                        errors++;
                        $display("FAIL rr_spacing_%0d: got %0d want 7", ng, n - last_g);
                    end
                end
                last_g = n;
                ng++;
                if (ng == 5) req = '0;
            end
            if (done && nd < 5) begin
                checks++;
                if (done_id !== 2'(order[nd])) begin
                    errors++;
                    $display("FAIL rr_done_id_%0d: got %0d want %0d", nd, done_id, order[nd]);
                end
                checks++;
                if (sum !== exp_s[done_id] || cout !== exp_c[done_id]) begin
                    errors++;
                    $display("FAIL rr_result_%0d: got sum=%0d cout=%b want sum=%0d cout=%b",
                             nd, sum, cout, exp_s[done_id], exp_c[done_id]);
                end
                nd++;
                if (nd == 5) break;
            end
        end
        checks++;
        if (ng !== 5 || nd !== 5) begin
            errors++;
            $display("FAIL rr_count: got grants=%0d dones=%0d want 5 and 5", ng, nd);
        end
        checks++;
        if (ov !== 0) begin
            errors++;
            $display("FAIL rr_gnt_done_overlap: got %0d want 0", ov);
        end
        req = '0;
        tick();
    endtask

    task automatic test_skip_wrap();
        int gt, gc, dt, bl, ov; logic [3:0] g, s; logic c, ba; logic [1:0] id;
        do_reset();
        set_ops(2, 4'd6, 4'd6);
        run_req(4'b0100, gt, gc, dt, g, s, c, id, bl, ov, ba);
        checks++; if (g !== 4'b0100 || s !== 4'd12) begin
            errors++; $display("FAIL skip_first: got gnt=%b sum=%0d want 0100 and 12", g, s);
        end
        set_ops(0, 4'd1, 4'd2);
        set_ops(2, 4'd12, 4'd5);
        run_req(4'b0101, gt, gc, dt, g, s, c, id, bl, ov, ba);
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL wrap_gnt: got %b want 0001", g); end
        checks++; if (s !== 4'd3 || id !== 2'd0) begin
            errors++; $display("FAIL wrap_result: got sum=%0d id=%0d want 3 and 0", s, id);
        end
        checks++; if (bl !== 0) begin errors++; $display("FAIL wrap_busy_gap: got %0d low cycles want 0", bl); end
        run_req(4'b0100, gt, gc, dt, g, s, c, id, bl, ov, ba);
        checks++; if (g !== 4'b0100 || gt !== 1) begin
            errors++; $display("FAIL wrap_second: got gnt=%b at tick %0d want 0100 at 1", g, gt);
        end
        checks++; if (s !== 4'd1 || c !== 1'b1 || id !== 2'd2) begin
            errors++; $display("FAIL wrap_second_result: got sum=%0d cout=%b id=%0d want 1 1 2", s, c, id);
        end
        req = '0;
    endtask

    task automatic test_reset_mid_shift();
        int gt, gc, dt, bl, ov; logic [3:0] g, s; logic c, ba; logic [1:0] id;
        do_reset();
        set_ops(0, 4'd5, 4'd6);
        set_ops(1, 4'd2, 4'd3);
        req = 4'b0001;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_gnt: got %b want 0001", gnt); end
        req = '0;
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
        reset = 1'b0;
        tick();
        checks++;
        if ({gnt, busy, done, done_id, sum, cout} !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got gnt=%b busy=%b done=%b id=%0d sum=%0d cout=%b, want all 0",
                     gnt, busy, done, done_id, sum, cout);
        end
        reset = 1'b1;
        run_req(4'b0010, gt, gc, dt, g, s, c, id, bl, ov, ba);
        checks++; if (gt !== 1 || g !== 4'b0010) begin
            errors++; $display("FAIL mid_after_gnt: got gnt=%b at tick %0d want 0010 at 1", g, gt);
        end
        checks++; if (dt !== 6 || s !== 4'd5 || id !== 2'd1) begin
            errors++; $display("FAIL mid_after_result: got done@%0d sum=%0d id=%0d want 6 5 1", dt, s, id);
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        int gt, gc, dt, bl, ov; logic [3:0] g, s; logic c, ba; logic [1:0] id;
        sub = 4'b0001;
        set_ops(0, 4'd3, 4'd5);
        run_req(4'b0001, gt, gc, dt, g, s, c, id, bl, ov, ba);
        checks++; if (s !== 4'd14 || c !== 1'b0) begin
            errors++; $display("FAIL sub_borrow: got sum=%0d cout=%b want 14 0", s, c);
        end
        set_ops(0, 4'd7, 4'd2);
        run_req(4'b0001, gt, gc, dt, g, s, c, id, bl, ov, ba);
        checks++; if (s !== 4'd5 || c !== 1'b1) begin
            errors++; $display("FAIL sub_noborrow: got sum=%0d cout=%b want 5 1", s, c);
        end
        sub = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_add();
        test_overflow();
        test_round_robin();
        test_skip_wrap();
        test_reset_mid_shift();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
